// File: rtl/keycode_motion_queue.sv
// Keycode-to-motion command queue.
// Converts W/A/S/D key presses into direction commands, buffers them in a
// small FIFO and pops at most one per vertical-sync frame edge, presenting
// signed per-frame X/Y motion plus a one-cycle frame tick.
// Optional feature: define KEYCMD_STOP_ON_RELEASE_EN to push STOP when a
// mapped key is released.
module keycode_motion_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [7:0]              keycode,
  input  logic                    vs,
  output logic [9:0]              Motion_X,
  output logic [9:0]              Motion_Y,
  output logic                    frame_tick,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [9:0]  StepV = 10'(STEP);

  typedef enum logic [2:0] {
    CmdNone, CmdUp, CmdDown, CmdLeft, CmdRight, CmdStop
  } cmd_e;

  function automatic cmd_e map_key(logic [7:0] kc);
    case (kc)
      8'h1A:   return CmdUp;
      8'h04:   return CmdLeft;
      8'h16:   return CmdDown;
      8'h07:   return CmdRight;
      default: return CmdNone;
    endcase
  endfunction

  logic [7:0]      kc_q, kc_prev_q;
  logic            vs_q;
  cmd_e            mem_q [DEPTH];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;
  cmd_e            dir_q, dir_d;
  logic [9:0]      mx_q, mx_d, my_q, my_d;
  logic            tick_q, tick_d;
  logic            ovf_q, ovf_d;

  cmd_e push_cmd;
  logic push, push_ok, pop, frame_edge, full, empty;

  // Command decode, FIFO control, direction and motion next-state.
  always_comb begin
    push_cmd = map_key(kc_q);
    push     = (kc_q != kc_prev_q) && (kc_q != 8'h00) && (push_cmd != CmdNone);
`ifdef KEYCMD_STOP_ON_RELEASE_EN
    if ((kc_q == 8'h00) && (map_key(kc_prev_q) != CmdNone)) begin
      push     = 1'b1;
      push_cmd = CmdStop;
    end
`endif
    frame_edge = vs_q & ~vs;
    full       = (count_q == CntW'(DEPTH));
    empty      = (count_q == '0);
    // An empty FIFO never pops, even if a push lands on the same edge.
    pop        = frame_edge & ~empty;
    // A pop on the same cycle frees the slot a full FIFO needs.
    push_ok    = push & (~full | pop);

    wr_d    = wr_q + PtrW'(push_ok);
    rd_d    = rd_q + PtrW'(pop);
    count_d = count_q + CntW'(push_ok) - CntW'(pop);
    ovf_d   = ovf_q | (push & full & ~pop);
    dir_d   = pop ? mem_q[rd_q] : dir_q;
    tick_d  = frame_edge;

    mx_d = mx_q;
    my_d = my_q;
    if (frame_edge) begin
      mx_d = '0;
      my_d = '0;
      unique case (dir_d)
        CmdUp:    my_d = -StepV;
        CmdDown:  my_d = StepV;
        CmdLeft:  mx_d = -StepV;
        CmdRight: mx_d = StepV;
        default: ;
      endcase
    end
  end

  // Control and output state with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      kc_q      <= '0;
      kc_prev_q <= '0;
      vs_q      <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      dir_q     <= CmdNone;
      mx_q      <= '0;
      my_q      <= '0;
      tick_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      kc_q      <= keycode;
      kc_prev_q <= kc_q;
      vs_q      <= vs;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
    end
  end

  // Command storage; contents are don't-care outside the valid window.
  always_ff @(posedge Clk) begin
    if (Reset_n && push_ok) begin
      mem_q[wr_q] <= push_cmd;
    end
  end

  assign Motion_X   = mx_q;
  assign Motion_Y   = my_q;
  assign frame_tick = tick_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
